// File: rtl/tc_pl_acp_tx_arb.sv
// -----------------------------------------------------------------------------
// tc_pl_acp_tx_arb
//
// Round-robin arbiter that shares the single ACP0 write port between N_REQ
// capture-to-ACP transmit engines. One burst is granted at a time. The arbiter
// registers the winner's address and ID onto the shared port, and steers the
// shared rdy/wdreq strobes back to the granted requester. The granted
// requester's write data is muxed onto the shared port. The block also checks
// the beat count of each burst, abandons hung grants after TIMEOUT cycles, and
// counts completed bursts.
//
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   arb_en             allows new grants (a burst in flight always completes)
//   err_clr            synchronous clear of the sticky error flags
//   req_en/awaddr/wdata  per-requester request, burst address, write data
//   req_rdy/req_wdreq    per-requester ready and data-beat strobes
//   acp_tx_*           shared ACP0 write port
//   busy, grant_id     grant held / index of current or last grant
//   err_len            sticky: a burst completed with beats != BURST_LEN
//   err_timeout        sticky: a grant was abandoned after TIMEOUT cycles
//   burst_cnt          completed bursts, wraps at 2^32
// -----------------------------------------------------------------------------
module tc_pl_acp_tx_arb #(
  parameter int N_REQ     = 4,
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arb_en,
  input  logic                 err_clr,
  input  logic [N_REQ-1:0]     req_en,
  input  logic [N_REQ*32-1:0]  req_awaddr,
  input  logic [N_REQ*64-1:0]  req_wdata,
  output logic [N_REQ-1:0]     req_rdy,
  output logic [N_REQ-1:0]     req_wdreq,
  output logic                 acp_tx_en,
  input  logic                 acp_tx_rdy,
  output logic [31:0]          acp_tx_awaddr,
  output logic [2:0]           acp_tx_awid,
  output logic [63:0]          acp_tx_wdata,
  input  logic                 acp_tx_wdreq,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 err_len,
  output logic                 err_timeout,
  output logic [31:0]          burst_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_GAP} state_t;

  localparam logic [7:0]  BEATS_EXP = 8'(BURST_LEN);
  // Last value of the grant cycle counter before the grant is abandoned; the
  // counter starts at 0 in the first ADDR cycle, so this is the TIMEOUT-th cycle.
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [2:0]  last_grant;
  logic [7:0]  beat_cnt;
  logic [15:0] to_cnt;

  logic        in_grant;
  logic        to_hit;
  logic        do_grant, addr_ack, do_done, do_abort;
  logic [7:0]  beat_inc, beats_final;
  logic        len_set;

  logic [2:0]  win_idx;
  logic [31:0] win_addr;
  int          rr_dist, best_dist;

  assign in_grant = (state == S_ADDR) || (state == S_DATA);
  assign to_hit   = (TIMEOUT != 0) && in_grant && (to_cnt == TO_LAST);

  // Beat count including a beat arriving in the completion cycle itself.
  assign beat_inc    = (beat_cnt == 8'hFF) ? beat_cnt : beat_cnt + 8'd1;
  assign beats_final = acp_tx_wdreq ? beat_inc : beat_cnt;
  assign len_set     = do_done && (beats_final != BEATS_EXP);

  // Round-robin winner: the set request with the smallest distance above
  // last_grant (wrapping), so last_grant itself has the lowest priority.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned; otherwise a latch is inferred.
    win_idx   = '0;
    win_addr  = '0;
    rr_dist   = 0;
    best_dist = N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      rr_dist = (i + 2 * N_REQ - 1 - int'(last_grant)) % N_REQ;
      if (req_en[i] && (rr_dist < best_dist)) begin
        best_dist = rr_dist;
        win_idx   = 3'(i);
        win_addr  = req_awaddr[32*i +: 32];
      end
    end
  end

  // Next-state and control strobes. A slave rdy in the same cycle as the
  // timeout wins, so a burst that really finished is never reported as hung.
  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    addr_ack  = 1'b0;
    do_done   = 1'b0;
    do_abort  = 1'b0;
    case (state)
      S_IDLE: if (arb_en && (|req_en)) begin
        do_grant  = 1'b1;
        state_nxt = S_ADDR;
      end
      S_ADDR: if (acp_tx_rdy) begin
        addr_ack  = 1'b1;
        state_nxt = S_DATA;
      end else if (to_hit) begin
        do_abort  = 1'b1;
        state_nxt = S_GAP;
      end
      S_DATA: if (acp_tx_rdy) begin
        do_done   = 1'b1;
        state_nxt = S_GAP;
      end else if (to_hit) begin
        do_abort  = 1'b1;
        state_nxt = S_GAP;
      end
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values, independent of statement order.
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acp_tx_en     <= 1'b0;
      acp_tx_awaddr <= '0;
      acp_tx_awid   <= '0;
      grant_id      <= '0;
      busy          <= 1'b0;
      last_grant    <= 3'(N_REQ - 1);
      beat_cnt      <= '0;
      to_cnt        <= '0;
      err_len       <= 1'b0;
      err_timeout   <= 1'b0;
      burst_cnt     <= '0;
    end else begin
      if (do_grant) begin
        grant_id      <= win_idx;
        acp_tx_awid   <= win_idx;
        acp_tx_awaddr <= win_addr;
        acp_tx_en     <= 1'b1;
        busy          <= 1'b1;
        to_cnt        <= '0;
      end else if (in_grant) begin
        to_cnt <= to_cnt + 16'd1;
      end

      if (addr_ack || do_abort) acp_tx_en <= 1'b0;

      if (addr_ack)                           beat_cnt <= '0;
      else if (state == S_DATA && acp_tx_wdreq) beat_cnt <= beat_inc;

      if (do_done)             burst_cnt  <= burst_cnt + 32'd1;
      if (do_done || do_abort) last_grant <= grant_id;

      if (state == S_GAP) busy <= 1'b0;

      // Set has priority over clear.
      if (len_set)      err_len <= 1'b1;
      else if (err_clr) err_len <= 1'b0;

      if (do_abort)     err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

  // Strobe and data steering from the registered grant index.
  always_comb begin
    req_rdy      = '0;
    req_wdreq    = '0;
    acp_tx_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == 3'(i)) begin
        req_rdy[i]   = acp_tx_rdy & in_grant;
        req_wdreq[i] = acp_tx_wdreq & (state == S_DATA);
        acp_tx_wdata = req_wdata[64*i +: 64];
      end
    end
  end

endmodule

// File: tb/tb_tc_pl_acp_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_tc_pl_acp_tx_arb
//
// Directed self-checking bench for tc_pl_acp_tx_arb (N_REQ=4, BURST_LEN=16,
// TIMEOUT=64). The bench plays the ACP0 slave; expected values are hand-derived
// constants and a small burst counter kept by the bench.
// -----------------------------------------------------------------------------
module tb_tc_pl_acp_tx_arb;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          arb_en = 1'b0;
  logic          err_clr = 1'b0;
  logic [3:0]    req_en = '0;
  logic [127:0]  req_awaddr;
  logic [255:0]  req_wdata;
  logic [3:0]    req_rdy, req_wdreq;
  logic          acp_tx_en;
  logic          acp_tx_rdy = 1'b0;
  logic [31:0]   acp_tx_awaddr;
  logic [2:0]    acp_tx_awid;
  logic [63:0]   acp_tx_wdata;
  logic          acp_tx_wdreq = 1'b0;
  logic          busy;
  logic [2:0]    grant_id;
  logic          err_len, err_timeout;
  logic [31:0]   burst_cnt;

  logic [31:0] addr_tab [4];
  logic [63:0] data_tab [4];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_bursts = 0;
  int wd_cnt [4];

  tc_pl_acp_tx_arb #(.N_REQ(N), .BURST_LEN(16), .TIMEOUT(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .arb_en       (arb_en),
    .err_clr      (err_clr),
    .req_en       (req_en),
    .req_awaddr   (req_awaddr),
    .req_wdata    (req_wdata),
    .req_rdy      (req_rdy),
    .req_wdreq    (req_wdreq),
    .acp_tx_en    (acp_tx_en),
    .acp_tx_rdy   (acp_tx_rdy),
    .acp_tx_awaddr(acp_tx_awaddr),
    .acp_tx_awid  (acp_tx_awid),
    .acp_tx_wdata (acp_tx_wdata),
    .acp_tx_wdreq (acp_tx_wdreq),
    .busy         (busy),
    .grant_id     (grant_id),
    .err_len      (err_len),
    .err_timeout  (err_timeout),
    .burst_cnt    (burst_cnt)
  );

  always #5 clk = ~clk;

  // Count forwarded data-beat strobes per requester, sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) if (req_wdreq[i]) wd_cnt[i]++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int limit, output int waited);
    waited = 0;
    while (waited < limit && !acp_tx_en) begin
      tick();
      waited++;
    end
    check("grant_seen", 64'(acp_tx_en), 64'd1);
  endtask

  // One full slave-side burst: address rdy, nbeats wdreq, completion rdy.
  task automatic run_burst(input int nbeats, input logic [1:0] exp_id, input bit drop,
                           output int waited);
    logic [3:0] one;
    one = 4'b0001 << exp_id;
    wait_grant(100, waited);
    if (!acp_tx_en) return;
    check("awid",   64'(acp_tx_awid),   64'(exp_id));
    check("grant",  64'(grant_id),      64'(exp_id));
    check("awaddr", 64'(acp_tx_awaddr), 64'(addr_tab[exp_id]));
    check("busy",   64'(busy),          64'd1);
    acp_tx_rdy = 1'b1;
    #1;
    check("req_rdy_addr", 64'(req_rdy), 64'(one));
    if (drop) req_en = req_en & ~one;
    tick();
    acp_tx_rdy = 1'b0;
    check("en_after_rdy", 64'(acp_tx_en), 64'd0);
    acp_tx_wdreq = (nbeats > 0);
    for (int b = 0; b < nbeats; b++) begin
      if (b == 0) begin
        #1;
        check("wdata", acp_tx_wdata, data_tab[exp_id]);
        check("req_wdreq", 64'(req_wdreq), 64'(one));
      end
      tick();
    end
    acp_tx_wdreq = 1'b0;
    acp_tx_rdy   = 1'b1;
    #1;
    check("req_rdy_done", 64'(req_rdy), 64'(one));
    tick();
    acp_tx_rdy = 1'b0;
    exp_bursts++;
    check("burst_cnt", 64'(burst_cnt), 64'(exp_bursts));
  endtask

  initial begin
    int w;
    int s;
    addr_tab = '{32'h0800_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
    data_tab = '{64'hA0A0_0000_1111_0000, 64'hB1B1_0000_2222_0001,
                 64'hC2C2_0000_3333_0002, 64'hD3D3_0000_4444_0003};
    for (int i = 0; i < N; i++) begin
      req_awaddr[32*i +: 32] = addr_tab[i];
      req_wdata[64*i +: 64]  = data_tab[i];
    end

    // Reset values.
    #12;
    check("rst_en",     64'(acp_tx_en),     64'd0);
    check("rst_busy",   64'(busy),          64'd0);
    check("rst_gid",    64'(grant_id),      64'd0);
    check("rst_awid",   64'(acp_tx_awid),   64'd0);
    check("rst_awaddr", 64'(acp_tx_awaddr), 64'd0);
    check("rst_bcnt",   64'(burst_cnt),     64'd0);
    check("rst_elen",   64'(err_len),       64'd0);
    check("rst_eto",    64'(err_timeout),   64'd0);
    check("rst_rdy",    64'(req_rdy),       64'd0);
    check("rst_wdata",  acp_tx_wdata,       data_tab[0]);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Single request from requester 1: grant visible one cycle later.
    arb_en = 1'b1;
    req_en = 4'b0010;
    s = wd_cnt[1];
    run_burst(16, 2'd1, 1'b1, w);
    check("single_latency", 64'(w), 64'd1);
    check("single_beats", 64'(wd_cnt[1] - s), 64'd16);
    check("single_elen", 64'(err_len), 64'd0);

    // Gating: arb_en low blocks the grant; stray strobes in IDLE are ignored.
    tick();
    tick();
    arb_en = 1'b0;
    req_en = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      acp_tx_wdreq = 1'b1;
      acp_tx_rdy   = (k == 2);
      #1;
      check("gate_en", 64'(acp_tx_en), 64'd0);
      check("idle_wdreq", 64'(req_wdreq), 64'd0);
      check("idle_rdy", 64'(req_rdy), 64'd0);
      tick();
    end
    acp_tx_wdreq = 1'b0;
    acp_tx_rdy   = 1'b0;
    check("idle_bcnt", 64'(burst_cnt), 64'(exp_bursts));
    arb_en = 1'b1;
    tick();
    check("arb_en_grant", 64'(acp_tx_en), 64'd1);
    run_burst(16, 2'd0, 1'b1, w);
    check("gate_elen", 64'(err_len), 64'd0);

    // Length error: 15 beats sets err_len; a good burst keeps it; err_clr clears.
    req_en = 4'b0100;
    run_burst(15, 2'd2, 1'b1, w);
    check("len_set", 64'(err_len), 64'd1);
    tick();
    tick();
    check("len_sticky", 64'(err_len), 64'd1);
    req_en = 4'b1000;
    run_burst(16, 2'd3, 1'b1, w);
    check("len_keep", 64'(err_len), 64'd1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("len_clr", 64'(err_len), 64'd0);

    // Timeout: slave never answers; grant is dropped after 64 cycles.
    req_en = 4'b0010;
    wait_grant(100, w);
    req_en = 4'b0000;
    for (int c = 1; c <= 66; c++) begin
      tick();
      if (c == 63) begin
        check("to_early", 64'(err_timeout), 64'd0);
        check("to_early_en", 64'(acp_tx_en), 64'd1);
      end
      if (c == 64) begin
        check("to_set", 64'(err_timeout), 64'd1);
        check("to_en", 64'(acp_tx_en), 64'd0);
      end
      if (c == 66) begin
        check("to_busy", 64'(busy), 64'd0);
        check("to_bcnt", 64'(burst_cnt), 64'(exp_bursts));
      end
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to_clr", 64'(err_timeout), 64'd0);

    // Reset in the middle of a data phase (requester 2 wins after last=1).
    req_en = 4'b0100;
    wait_grant(100, w);
    check("mid_awid", 64'(acp_tx_awid), 64'd2);
    acp_tx_rdy = 1'b1;
    tick();
    acp_tx_rdy   = 1'b0;
    acp_tx_wdreq = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("mrst_en",     64'(acp_tx_en),     64'd0);
    check("mrst_awaddr", 64'(acp_tx_awaddr), 64'd0);
    check("mrst_awid",   64'(acp_tx_awid),   64'd0);
    check("mrst_gid",    64'(grant_id),      64'd0);
    check("mrst_busy",   64'(busy),          64'd0);
    check("mrst_bcnt",   64'(burst_cnt),     64'd0);
    check("mrst_wdreq",  64'(req_wdreq),     64'd0);
    check("mrst_wdata",  acp_tx_wdata,       data_tab[0]);
    acp_tx_wdreq = 1'b0;
    exp_bursts   = 0;
    req_en       = 4'b0101;
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("post_rst_awid", 64'(acp_tx_awid), 64'd0);
    // Contention: all requesters held high, rotation 0,1,2,3,0,1,2,3.
    req_en = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      run_burst(16, 2'(k % 4), 1'b0, w);
      if (k > 0) check("gap_cycles", 64'(w + 1), 64'd3);
    end
    check("cont_bcnt", 64'(burst_cnt), 64'd8);
    req_en = 4'b0000;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tc_pl_acp_tx_arb.md
# tc_pl_acp_tx_arb

Round-robin arbiter that shares the single ACP0 write port between up to `N_REQ` capture-to-ACP transmit engines. Each requester uses the same address/data/completion handshake it would use on a dedicated port. The arbiter grants one burst at a time, drives the shared port's address and ID, and steers the `rdy`/`wdreq` strobes and write data. It also checks burst length, watches for hung transfers, and counts completed bursts. It sits between the per-channel capture transmitters and the ACP0 master.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `BURST_LEN`, 16: expected `wdreq` beats per burst (64-bit beats).
- `TIMEOUT`, 4096: maximum cycles a grant may stay in ADDR+DATA; 0 disables the check.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-low reset.
- `arb_en`  in  1  high allows new grants; low blocks new grants, and a burst already in progress completes normally.
- `err_clr`  in  1  synchronous clear of the sticky error flags.
- `req_en`  in  N_REQ  per-requester burst request; held from request until that requester sees its first `req_rdy`.
- `req_awaddr`  in  N_REQ*32  per-requester burst address, slice i = [32*i+:32].
- `req_wdata`  in  N_REQ*64  per-requester write data, slice i = [64*i+:64].
- `req_rdy`  out  N_REQ  per-requester ready strobe (address accepted / burst done).
- `req_wdreq`  out  N_REQ  per-requester data-beat request.
- `acp_tx_en`  out  1  shared-port address request.
- `acp_tx_rdy`  in  1  shared-port ready strobe.
- `acp_tx_awaddr`  out  32  shared-port burst address.
- `acp_tx_awid`  out  3  shared-port burst ID; equals the grant index.
- `acp_tx_wdata`  out  64  shared-port write data.
- `acp_tx_wdreq`  in  1  shared-port data-beat request.
- `busy`  out  1  high while a grant is held.
- `grant_id`  out  3  index of the current or most recent grant.
- `err_len`  out  1  sticky: a burst completed with a beat count different from `BURST_LEN`.
- `err_timeout`  out  1  sticky: a grant was abandoned because `TIMEOUT` expired.
- `burst_cnt`  out  32  count of completed bursts; wraps at 2^32.

## Operation
- FSM states: S_IDLE, S_ADDR, S_DATA, S_GAP.
- S_IDLE → S_ADDR when `arb_en` is high and any `req_en` bit is set.
  - Winner: the first set bit searching upward from `last_grant+1`, wrapping modulo `N_REQ`.
  - On entry, register `grant_id`, `acp_tx_awaddr` (the winner's slice) and `acp_tx_awid` (= `grant_id`), and set `acp_tx_en` and `busy` high.
- S_ADDR → S_DATA on `acp_tx_rdy`.
  - `acp_tx_en` goes low next cycle.
  - The beat counter clears.
- S_DATA:
  - Each `acp_tx_wdreq` increments an 8-bit beat counter, saturating at 255.
  - On `acp_tx_rdy`: `burst_cnt`+1; `err_len` is set if beats ≠ `BURST_LEN`; `last_grant` ← `grant_id`; go to S_GAP.
- S_GAP → S_IDLE unconditionally; `busy` goes low on entering S_IDLE.
- Combinational steering, using the registered `grant_id`:
  - `req_rdy[g] = acp_tx_rdy & (state==S_ADDR | state==S_DATA)`.
  - `req_wdreq[g] = acp_tx_wdreq & (state==S_DATA)`.
  - All other bits are 0.
  - `acp_tx_wdata` = slice `grant_id` of `req_wdata` in every state.
- Strobes outside a grant are ignored:
  - `acp_tx_wdreq` in S_ADDR, S_GAP or S_IDLE is not forwarded and not counted.
  - `acp_tx_rdy` in S_IDLE or S_GAP is ignored.
- Timeout: a 16-bit cycle counter runs in S_ADDR and S_DATA. If it reaches `TIMEOUT` (when nonzero):
  - set `err_timeout`, drop `acp_tx_en`, update `last_grant` and go to S_GAP;
  - `burst_cnt` is not incremented.
- `err_clr` clears both error flags. If a set and a clear occur in the same cycle, set wins.
- Reset (async, any state, including mid-burst):
  - S_IDLE;
  - `acp_tx_en`=0, `acp_tx_awaddr`=0, `acp_tx_awid`=0, `grant_id`=0, `busy`=0;
  - `err_len`=0, `err_timeout`=0, `burst_cnt`=0;
  - `last_grant`=`N_REQ`-1, so requester 0 has priority after reset.
  - `req_rdy`, `req_wdreq` and `acp_tx_wdata` follow combinationally (0, 0, slice 0).

## Timing
- Grant latency: request seen in S_IDLE at cycle t → `acp_tx_en`, `acp_tx_awaddr`, `acp_tx_awid` valid at t+1.
- `acp_tx_rdy` at cycle t in S_ADDR → `req_rdy[g]` high in cycle t (same cycle); `acp_tx_en` low at t+1.
- Completion `acp_tx_rdy` at cycle t → S_GAP at t+1, S_IDLE at t+2, next `acp_tx_en` no earlier than t+3.
- Write data has zero added latency: a requester updates its own slice after its `req_wdreq`, and that value appears on `acp_tx_wdata` the same cycle.
- `arb_en` falling during S_ADDR/S_DATA does not affect the current burst.
- `req_en` changes during a grant have no effect until S_IDLE.

## Test plan
- Single request: requester 1, `req_awaddr`=0x1000_0000; slave gives `rdy`, 16 `wdreq`, `rdy`.
  - `acp_tx_awid`=1 and `awaddr`=0x1000_0000 one cycle after the request.
  - 16 `req_wdreq[1]` pulses; `burst_cnt`=1; `err_len`=0.
- Contention: all 4 `req_en` held high for 8 bursts.
  - Grant order 0,1,2,3,0,1,2,3; `burst_cnt`=8.
  - Gap of ≥3 cycles between completion `rdy` and the next `acp_tx_en`.
- Length error: only 15 `wdreq` beats, then `rdy`.
  - `err_len`=1 and stays set.
  - Next burst with 16 beats keeps `err_len`=1.
  - `err_clr` pulse → `err_len`=0.
- Timeout: `TIMEOUT`=64; slave never asserts `rdy` after `acp_tx_en`.
  - `err_timeout`=1 at 64 cycles; `acp_tx_en`=0; `busy`=0 two cycles later; `burst_cnt` unchanged.
- Gating/ignored strobes: `arb_en`=0 with requests pending → no `acp_tx_en`; `wdreq` pulses in S_IDLE are not forwarded.
  - Raise `arb_en` → grant on the next cycle.
- Reset mid-burst: assert `rst`=0 during S_DATA.
  - All outputs reach their reset values immediately (asynchronously).
  - After release, requester 0 wins against requester 2.
